// File: rtl/midi_voice_allocator_if.sv
// Note-event bus from the MIDI receiver into the voice allocator.
interface midi_voice_allocator_if #(
   parameter int unsigned NOTE_BITS = 7
);
   logic                 ready;
   logic                 value;
   logic [NOTE_BITS-1:0] note;
   logic [NOTE_BITS-1:0] velocity;

   modport master (output ready, value, note, velocity);
   modport slave  (input  ready, value, note, velocity);
endinterface

// File: rtl/midi_voice_allocator.sv
// Maps note-on/note-off events onto a bank of synth voices: retrigger a held key,
// else take the lowest free voice, else steal the least-recently-allocated one.
module midi_voice_allocator #(
   parameter int unsigned VOICES    = 4,
   parameter int unsigned NOTE_BITS = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   midi_voice_allocator_if.slave         i_midi,
   output logic [VOICES-1:0]             o_voice_gate,
   output logic [VOICES*NOTE_BITS-1:0]   o_voice_note,
   output logic [VOICES*NOTE_BITS-1:0]   o_voice_velocity,
   output logic [VOICES-1:0]             o_voice_trig,
   output logic                          o_busy,
   output logic                          o_overflow
);
   localparam int unsigned RW = $clog2(VOICES);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

   state_t               r_state;
   logic                 r_ready_prev;
   logic                 r_evt_on;
   logic [NOTE_BITS-1:0] r_evt_note, r_evt_vel;
   logic                 r_pend_valid, r_pend_on;
   logic [NOTE_BITS-1:0] r_pend_note, r_pend_vel;
   logic [RW-1:0]        r_idx, r_match, r_free, r_old;
   logic                 r_match_found, r_free_found;
   logic [RW-1:0]        r_rank [VOICES];
   logic [VOICES-1:0]    r_gate, r_trig;
   logic [NOTE_BITS-1:0] r_note [VOICES];
   logic [NOTE_BITS-1:0] r_vel  [VOICES];
   logic                 r_busy, r_overflow;

   logic                 w_edge, w_ctrl, w_on, w_accept;
   logic [RW-1:0]        w_target;

   // Controller events (value=0, note=0) never enter the allocator
   assign w_edge   = i_midi.ready & ~r_ready_prev;
   assign w_ctrl   = ~i_midi.value & (i_midi.note == '0);
   assign w_on     = i_midi.value & (i_midi.velocity != '0);
   assign w_accept = w_edge & ~w_ctrl;
   assign w_target = r_match_found ? r_match : (r_free_found ? r_free : r_old);

   genvar g;
   generate
      for (g = 0; g < int'(VOICES); g++) begin : g_out
         assign o_voice_note[g*NOTE_BITS +: NOTE_BITS]     = r_note[g];
         assign o_voice_velocity[g*NOTE_BITS +: NOTE_BITS] = r_vel[g];
      end
   endgenerate

   assign o_voice_gate = r_gate;
   assign o_voice_trig = r_trig;
   assign o_busy       = r_busy;
   assign o_overflow   = r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_ready_prev  <= 1'b0;
         r_evt_on      <= 1'b0;
         r_evt_note    <= '0;
         r_evt_vel     <= '0;
         r_pend_valid  <= 1'b0;
         r_pend_on     <= 1'b0;
         r_pend_note   <= '0;
         r_pend_vel    <= '0;
         r_idx         <= '0;
         r_match       <= '0;
         r_free        <= '0;
         r_old         <= '0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_gate        <= '0;
         r_trig        <= '0;
         r_busy        <= 1'b0;
         r_overflow    <= 1'b0;
         for (int k = 0; k < int'(VOICES); k++) begin
            r_rank[k] <= RW'(k);
            r_note[k] <= '0;
            r_vel[k]  <= '0;
         end
      end else begin
         r_ready_prev <= i_midi.ready;
         r_trig       <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_evt_on      <= w_on;
                  r_evt_note    <= i_midi.note;
                  r_evt_vel     <= i_midi.velocity;
                  r_idx         <= '0;
                  r_match_found <= 1'b0;
                  r_free_found  <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_gate[r_idx] && (r_note[r_idx] == r_evt_note) && !r_match_found) begin
                  r_match       <= r_idx;
                  r_match_found <= 1'b1;
               end
               if (!r_gate[r_idx] && !r_free_found) begin
                  r_free       <= r_idx;
                  r_free_found <= 1'b1;
               end
               if (r_rank[r_idx] == RW'(VOICES-1)) r_old <= r_idx;
               if (w_accept) begin
                  if (!r_pend_valid) begin
                     r_pend_valid <= 1'b1;
                     r_pend_on    <= w_on;
                     r_pend_note  <= i_midi.note;
                     r_pend_vel   <= i_midi.velocity;
                  end else begin
                     r_overflow <= 1'b1;
                  end
               end
               if (r_idx == RW'(VOICES-1)) r_state <= S_COMMIT;
               else                        r_idx   <= r_idx + RW'(1);
            end
            S_COMMIT: begin
               if (r_evt_on) begin
                  r_gate[w_target] <= 1'b1;
                  r_note[w_target] <= r_evt_note;
                  r_vel[w_target]  <= r_evt_vel;
                  r_trig[w_target] <= 1'b1;
                  for (int k = 0; k < int'(VOICES); k++)
                     if (r_rank[k] < r_rank[w_target]) r_rank[k] <= r_rank[k] + RW'(1);
                  r_rank[w_target] <= '0;
               end else if (r_match_found) begin
                  r_gate[r_match] <= 1'b0;
               end
               r_idx         <= '0;
               r_match_found <= 1'b0;
               r_free_found  <= 1'b0;
               // A waiting event (stored or arriving now) chains straight into the next scan
               if (r_pend_valid) begin
                  r_evt_on     <= r_pend_on;
                  r_evt_note   <= r_pend_note;
                  r_evt_vel    <= r_pend_vel;
                  r_pend_valid <= 1'b0;
                  r_state      <= S_SCAN;
                  if (w_accept) r_overflow <= 1'b1;
               end else if (w_accept) begin
                  r_evt_on   <= w_on;
                  r_evt_note <= i_midi.note;
                  r_evt_vel  <= i_midi.velocity;
                  r_state    <= S_SCAN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
